ramtest_bist: RTL and testbench
===============================

// Module: ramtest_bist
// PURPOSE
//  On-chip stand-in for the PC on the SDRAM test path, in the ti_clk domain.
//  - Write phase: drives the write-side port of the PipeIn FIFO with an LFSR pattern.
//  - Read phase: drains the read-side port of the PipeOut FIFO and checks it against a second, identical LFSR.
//  - Sequences the SDRAM read/write enables and the datapath reset between phases, then reports pass/fail.
// PARAMETERS
//  PAGE_WORDS  512       words per SDRAM page (negotiator transfer unit)
//  PAGE_COUNT  16        pages written then read back; total = PAGE_COUNT*PAGE_WORDS
//  SEED        16'hACE1  LFSR seed; 0 is replaced by 16'h0001
//  RST_CYCLES  16        width of the ctrl_rst pulse between phases
//  TIMEOUT     65535     cycles without FIFO progress before abort
// PORTS
//  ti_clk         in   1   host-interface clock
//  reset          in   1   synchronous, active-high
//  start          in   1   one-cycle request to begin a run
//  wf_wr_en       out  1   write enable into the PipeIn FIFO
//  wf_din         out  16  write data into the PipeIn FIFO
//  wf_full        in   1   PipeIn FIFO full
//  wf_wr_count    in   11  PipeIn FIFO write-side occupancy
//  rf_rd_en       out  1   read enable from the PipeOut FIFO
//  rf_dout        in   16  PipeOut FIFO data; valid the cycle after rf_rd_en
//  rf_empty       in   1   PipeOut FIFO empty
//  sdram_wren     out  1   replaces host WireIn bit 1
//  sdram_rden     out  1   replaces host WireIn bit 0
//  ctrl_rst       out  1   replaces host WireIn bit 2; resets FIFOs and row address
//  busy           out  1   run in progress
//  done           out  1   run finished; held until next start or reset
//  pass           out  1   done, error_count==0, no timeout
//  timeout        out  1   run aborted by the watchdog
//  error_count    out  16  mismatching words; saturates at 16'hFFFF
//  first_err_idx  out  24  word index of the first mismatch
//  first_err_exp  out  16  expected word at the first mismatch
//  first_err_act  out  16  received word at the first mismatch
// BEHAVIOUR
//  - Reset: all outputs 0; FSM to IDLE; both LFSRs = SEED.
//  - LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
//      Current state is the data word. It advances only on an accepted write or a checked read.
//  - IDLE: on start, clear status and counters, load both LFSRs, set busy, go to WRITE.
//      start is ignored while busy.
//  - WRITE: sdram_wren=1.
//      wf_wr_en=1 whenever !wf_full and wr_cnt<TOTAL; wf_din = gen LFSR.
//      wf_wr_en is never asserted while wf_full.
//      After TOTAL words, go to WFLUSH.
//  - WFLUSH: sdram_wren stays 1 until wf_wr_count==0, then go to RSTP.
//  - RSTP: sdram_wren=0; ctrl_rst=1 for RST_CYCLES cycles; then go to READ.
//  - READ: sdram_rden=1.
//      rf_rd_en=1 whenever !rf_empty and rd_cnt<TOTAL.
//      Compare is registered: rf_dout is checked one cycle after rf_rd_en, against chk LFSR, at index rd_idx.
//      On mismatch: error_count += 1 (saturating). On the first mismatch only, latch first_err_*.
//      After the TOTAL-th compare completes, go to DONE. Extra prefetched words are left unread.
//  - DONE: sdram_rden=0, busy=0, done=1, pass per definition; next start begins a new run.
//  - Watchdog: counts cycles in WRITE/WFLUSH/READ without a write or read; clears on progress.
//      At TIMEOUT: timeout=1, enables dropped, go to DONE.
//  - Latency: start to first wf_wr_en is 1 cycle.
//  - Counters are 24 bits; TOTAL must fit in 24 bits (checked at elaboration).
//  - Reset asserted mid-run: return to IDLE next edge; ctrl_rst deasserted; no partial status kept.
// STRUCTURE
//  - Shared package ramtest_pkg: LFSR polynomial/taps, FSM state encoding, PAGE_WORDS constant.
//  - Sub-module lfsr16 (enable, load, seed, q), instantiated twice: generator and checker.
//  - Top holds the FSM, counters, watchdog and the compare/capture pipeline stage.
// TESTING
//  1. Loopback model (FIFO + 1-page SDRAM model), PAGE_COUNT=2, start -> 1024 writes then 1024 reads;
//     done=1, pass=1, error_count=0.
//  2. Model flips bit 0 of word index 700 -> error_count=1, first_err_idx=700,
//     first_err_exp ^ first_err_act = 16'h0001.
//  3. wf_full forced high 50 cycles mid-WRITE -> wf_wr_en low throughout,
//     no skipped or duplicated pattern words, still pass.
//  4. rf_empty toggled every cycle in READ -> rf_rd_en only when !rf_empty, pass=1.
//  5. Model never drains the write FIFO, TIMEOUT=100 -> timeout=1, pass=0,
//     done within 101 cycles of the last write.
//  6. reset asserted during READ -> next cycle all outputs 0, IDLE; a following start completes with pass=1.

Source files
------------

// File: rtl/ramtest_pkg.sv
// Shared constants, FSM encoding and LFSR step for the SDRAM BIST.
// Latency: n/a (package).
// Backpressure: n/a (package).
package ramtest_pkg;

    localparam int unsigned DEF_PAGE_WORDS = 512;

    // Galois form of x^16 + x^14 + x^13 + x^11 + 1 (right shift, taps at bit exp-1)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WRITE  = 3'd1,
        S_WFLUSH = 3'd2,
        S_RSTP   = 3'd3,
        S_READ   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        lfsr_next = {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
    endfunction

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    function automatic logic [15:0] fix_seed(input logic [15:0] s);
        fix_seed = (s == 16'h0000) ? 16'h0001 : s;
    endfunction

endpackage

// File: rtl/ramtest_bist_lfsr16.sv
// 16-bit Galois LFSR; q is the current pattern word.
// Latency: q advances on the edge after enable, load takes priority.
// Backpressure: none; the owner gates enable.
module lfsr16
    import ramtest_pkg::*;
(
    input  logic        ti_clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    always_ff @(posedge ti_clk) begin
        if (reset || load) begin
            q <= fix_seed(seed);
        end else if (enable) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/ramtest_bist.sv
// SDRAM path self-test: writes an LFSR pattern into PipeIn, reads PipeOut back and checks it.
// Latency: first write 1 cycle after start; compare lands 1 cycle after each read.
// Backpressure: writes stall on wf_full, reads stall on rf_empty; watchdog aborts a stuck run.
module ramtest_bist
    import ramtest_pkg::*;
#(
    parameter int unsigned PAGE_WORDS = DEF_PAGE_WORDS,
    parameter int unsigned PAGE_COUNT = 16,
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter int unsigned RST_CYCLES = 16,
    parameter int unsigned TIMEOUT    = 65535
) (
    input  logic        ti_clk,
    input  logic        reset,
    input  logic        start,
    output logic        wf_wr_en,
    output logic [15:0] wf_din,
    input  logic        wf_full,
    input  logic [10:0] wf_wr_count,
    output logic        rf_rd_en,
    input  logic [15:0] rf_dout,
    input  logic        rf_empty,
    output logic        sdram_wren,
    output logic        sdram_rden,
    output logic        ctrl_rst,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [15:0] error_count,
    output logic [23:0] first_err_idx,
    output logic [15:0] first_err_exp,
    output logic [15:0] first_err_act
);

    localparam logic [63:0] TOTAL_W  = 64'(PAGE_WORDS) * 64'(PAGE_COUNT);
    localparam logic [23:0] TOTAL    = TOTAL_W[23:0];
    localparam int          WD_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [15:0]     RST_LAST = 16'(RST_CYCLES - 1);

    if (TOTAL_W == 64'd0 || TOTAL_W > 64'h0000_0000_00FF_FFFF) begin : g_total_range
        $error("ramtest_bist: PAGE_WORDS*PAGE_COUNT must lie in 1..2^24-1");
    end
    if (TIMEOUT == 0 || RST_CYCLES == 0 || RST_CYCLES > 65536) begin : g_param_range
        $error("ramtest_bist: TIMEOUT and RST_CYCLES must be non-zero");
    end

    state_t          state;
    logic [23:0]     wr_cnt;
    logic [23:0]     rd_cnt;
    logic [23:0]     rd_idx;
    logic            rd_pend;
    logic [WD_W-1:0] wd_cnt;
    logic [15:0]     rst_cnt;
    logic [15:0]     gen_q;
    logic [15:0]     chk_q;
    logic            lfsr_load;
    logic            mismatch;
    logic            progress;
    logic            wd_active;
    logic [15:0]     err_next;

    // Handshakes are combinational so wf_wr_en can never coincide with wf_full.
    assign wf_wr_en  = (state == S_WRITE) && !wf_full && (wr_cnt < TOTAL);
    assign rf_rd_en  = (state == S_READ) && !rf_empty && (rd_cnt < TOTAL);
    assign wf_din    = wf_wr_en ? gen_q : 16'h0000;
    assign lfsr_load = ((state == S_IDLE) || (state == S_DONE)) && start;

    assign mismatch  = rd_pend && (rf_dout != chk_q);
    assign err_next  = (mismatch && (error_count != 16'hFFFF)) ? error_count + 16'd1 : error_count;
    assign progress  = wf_wr_en || rf_rd_en || rd_pend;
    assign wd_active = (state == S_WRITE) || (state == S_WFLUSH) || (state == S_READ);

    lfsr16 u_gen (
        .ti_clk (ti_clk),
        .reset  (reset),
        .enable (wf_wr_en),
        .load   (lfsr_load),
        .seed   (SEED),
        .q      (gen_q)
    );

    lfsr16 u_chk (
        .ti_clk (ti_clk),
        .reset  (reset),
        .enable (rd_pend),
        .load   (lfsr_load),
        .seed   (SEED),
        .q      (chk_q)
    );

    always_ff @(posedge ti_clk) begin
        if (reset) begin
            state         <= S_IDLE;
            wr_cnt        <= '0;
            rd_cnt        <= '0;
            rd_idx        <= '0;
            rd_pend       <= 1'b0;
            wd_cnt        <= '0;
            rst_cnt       <= '0;
            sdram_wren    <= 1'b0;
            sdram_rden    <= 1'b0;
            ctrl_rst      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
            error_count   <= '0;
            first_err_idx <= '0;
            first_err_exp <= '0;
            first_err_act <= '0;
        end else begin
            // Registered compare stage: rf_dout is valid the cycle after rf_rd_en.
            if (rd_pend) begin
                error_count <= err_next;
                if (mismatch && (error_count == 16'h0000)) begin
                    first_err_idx <= rd_idx;
                    first_err_exp <= chk_q;
                    first_err_act <= rf_dout;
                end
                rd_idx <= rd_idx + 24'd1;
            end
            rd_pend <= rf_rd_en;
            if (wf_wr_en) wr_cnt <= wr_cnt + 24'd1;
            if (rf_rd_en) rd_cnt <= rd_cnt + 24'd1;

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state         <= S_WRITE;
                        sdram_wren    <= 1'b1;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        timeout       <= 1'b0;
                        error_count   <= '0;
                        first_err_idx <= '0;
                        first_err_exp <= '0;
                        first_err_act <= '0;
                        wr_cnt        <= '0;
                        rd_cnt        <= '0;
                        rd_idx        <= '0;
                        rd_pend       <= 1'b0;
                    end
                end
                S_WRITE: begin
                    if (wf_wr_en && (wr_cnt == TOTAL - 24'd1)) state <= S_WFLUSH;
                end
                S_WFLUSH: begin
                    if (wf_wr_count == 11'd0) begin
                        state      <= S_RSTP;
                        sdram_wren <= 1'b0;
                        ctrl_rst   <= 1'b1;
                        rst_cnt    <= '0;
                    end
                end
                S_RSTP: begin
                    if (rst_cnt == RST_LAST) begin
                        state      <= S_READ;
                        ctrl_rst   <= 1'b0;
                        sdram_rden <= 1'b1;
                    end else begin
                        rst_cnt <= rst_cnt + 16'd1;
                    end
                end
                S_READ: begin
                    if (rd_pend && (rd_idx == TOTAL - 24'd1)) begin
                        state      <= S_DONE;
                        sdram_rden <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        pass       <= (err_next == 16'h0000);
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Watchdog overrides any transition decided above.
            if (wd_active) begin
                if (progress) begin
                    wd_cnt <= '0;
                end else if (wd_cnt == WD_LAST) begin
                    state      <= S_DONE;
                    sdram_wren <= 1'b0;
                    sdram_rden <= 1'b0;
                    ctrl_rst   <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    pass       <= 1'b0;
                    timeout    <= 1'b1;
                    wd_cnt     <= '0;
                end else begin
                    wd_cnt <= wd_cnt + 1'b1;
                end
            end else begin
                wd_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ramtest_bist.sv
// Bench for ramtest_bist: FIFO + SDRAM loopback model, run results scoreboarded on done.
// Write stream is checked word by word against an LFSR sequence built from the polynomial.
module tb_ramtest_bist;

    localparam int PW       = 512;
    localparam int PC       = 2;
    localparam int TOT      = PW * PC;
    localparam int TMO      = 100;
    localparam int WF_DEPTH = 32;
    localparam logic [15:0] SEED_V   = 16'hACE1;
    localparam logic [15:0] TAP_MASK = (16'h1 << (16 - 1)) | (16'h1 << (14 - 1)) |
                                       (16'h1 << (13 - 1)) | (16'h1 << (11 - 1));

    logic        ti_clk = 1'b0;
    logic        reset  = 1'b1;
    logic        start  = 1'b0;
    logic        wf_wr_en;
    logic [15:0] wf_din;
    logic        wf_full = 1'b0;
    logic [10:0] wf_wr_count = 11'd0;
    logic        rf_rd_en;
    logic [15:0] rf_dout = 16'h0000;
    logic        rf_empty = 1'b1;
    logic        sdram_wren, sdram_rden, ctrl_rst, busy, done, pass, timeout;
    logic [15:0] error_count, first_err_exp, first_err_act;
    logic [23:0] first_err_idx;

    always #5 ti_clk = ~ti_clk;

    ramtest_bist #(
        .PAGE_WORDS (PW),
        .PAGE_COUNT (PC),
        .SEED       (SEED_V),
        .RST_CYCLES (16),
        .TIMEOUT    (TMO)
    ) dut (
        .ti_clk        (ti_clk),
        .reset         (reset),
        .start         (start),
        .wf_wr_en      (wf_wr_en),
        .wf_din        (wf_din),
        .wf_full       (wf_full),
        .wf_wr_count   (wf_wr_count),
        .rf_rd_en      (rf_rd_en),
        .rf_dout       (rf_dout),
        .rf_empty      (rf_empty),
        .sdram_wren    (sdram_wren),
        .sdram_rden    (sdram_rden),
        .ctrl_rst      (ctrl_rst),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .timeout       (timeout),
        .error_count   (error_count),
        .first_err_idx (first_err_idx),
        .first_err_exp (first_err_exp),
        .first_err_act (first_err_act)
    );

    typedef struct {
        bit          pass;
        bit          tmo;
        int          errs;
        int          fidx;
        logic [15:0] fexp;
        logic [15:0] fact;
    } exp_t;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] ref_w [TOT];
    logic [15:0] mem [TOT];
    exp_t        sb_q[$];
    exp_t        cur;
    logic [15:0] exp_wr[$];
    logic [15:0] wf_q[$];
    logic [15:0] rf_q[$];
    int          wa = 0, ra = 0, flip_idx = -1;
    bit          force_full = 0, tog_empty = 0, no_drain = 0, tog = 0;
    int          cyc = 0, last_wr_cyc = 0, full_viol = 0, empty_viol = 0, rd_mon = 0;
    bit          done_d = 0;
    bit          s_rst, s_we, s_re, s_wren, s_rden, s_crst;
    logic [15:0] s_din;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ctl"}, {wf_wr_en, rf_rd_en, sdram_wren, sdram_rden, ctrl_rst,
                              busy, done, pass, timeout}, 0);
        check({tag, "_din"}, wf_din, 0);
        check({tag, "_errcnt"}, error_count, 0);
        check({tag, "_fidx"}, first_err_idx, 0);
        check({tag, "_fexp_fact"}, {first_err_exp, first_err_act}, 0);
    endtask

    // Loopback model: PipeIn queue drains into SDRAM while wren; PipeOut prefetches while rden.
    initial begin
        forever begin
            @(negedge ti_clk);
            s_rst = reset; s_we = wf_wr_en; s_din = wf_din; s_re = rf_rd_en;
            s_wren = sdram_wren; s_rden = sdram_rden; s_crst = ctrl_rst;
            @(posedge ti_clk);
            #1;
            if (s_rst || s_crst) begin
                wf_q.delete(); rf_q.delete(); wa = 0; ra = 0;
            end else begin
                if (s_we) wf_q.push_back(s_din);
                if (s_wren && !no_drain && wf_q.size() > 0 && wa < TOT && $urandom_range(3) != 0) begin
                    mem[wa] = wf_q.pop_front() ^ ((wa == flip_idx) ? 16'h0001 : 16'h0000);
                    wa++;
                end
                if (s_re && rf_q.size() > 0) rf_dout = rf_q.pop_front();
                if (s_rden && ra < TOT && rf_q.size() < 16 && $urandom_range(3) != 0) begin
                    rf_q.push_back(mem[ra]);
                    ra++;
                end
            end
            tog = !tog;
            wf_wr_count = 11'(wf_q.size());
            wf_full = (wf_q.size() >= WF_DEPTH) || force_full;
            rf_empty = (rf_q.size() == 0) || (tog_empty && tog);
        end
    end

    // Monitor: write stream, handshake protocol, and the scoreboard pop on each done.
    initial begin
        forever begin
            @(negedge ti_clk);
            cyc++;
            if (wf_wr_en) begin
                last_wr_cyc = cyc;
                if (exp_wr.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL wr_extra actual=%0h required=no_write", wf_din);
                end else begin
                    check("wr_word", wf_din, exp_wr.pop_front());
                end
            end
            if (wf_wr_en && wf_full) full_viol++;
            if (rf_rd_en && rf_empty) empty_viol++;
            if (rf_rd_en) rd_mon++;
            if (done && !done_d) begin
                if (sb_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL done_unexpected actual=done required=no_done");
                end else begin
                    cur = sb_q.pop_front();
                    check("done_pass", pass, cur.pass);
                    check("done_timeout", timeout, cur.tmo);
                    check("done_errcnt", error_count, cur.errs);
                    check("done_idle_ctl", {busy, sdram_wren, sdram_rden, ctrl_rst}, 0);
                    check("wr_vs_full", full_viol, 0);
                    check("rd_vs_empty", empty_viol, 0);
                    if (cur.tmo) begin
                        checks++;
                        if (cyc - last_wr_cyc > TMO + 1) begin
                            failures++;
                            $display("FAIL tmo_latency actual=%0d required<=%0d", cyc - last_wr_cyc, TMO + 1);
                        end
                    end else begin
                        check("wr_total_left", exp_wr.size(), 0);
                        check("rd_total", rd_mon, TOT);
                    end
                    if (cur.errs > 0) begin
                        check("first_err_idx", first_err_idx, cur.fidx);
                        check("first_err_exp", first_err_exp, cur.fexp);
                        check("first_err_act", first_err_act, cur.fact);
                        check("first_err_xor", first_err_exp ^ first_err_act, 16'h0001);
                    end
                end
                full_viol = 0;
                empty_viol = 0;
            end
            done_d = done;
        end
    end

    task automatic run(input int mode, input bit push, input bit e_pass, input bit e_tmo,
                       input int e_errs, input int e_fidx);
        exp_t e;
        int   n;
        int   hold;
        if (push) begin
            e.pass = e_pass; e.tmo = e_tmo; e.errs = e_errs; e.fidx = e_fidx;
            e.fexp = (e_fidx >= 0) ? ref_w[e_fidx] : 16'h0000;
            e.fact = (e_fidx >= 0) ? (ref_w[e_fidx] ^ 16'h0001) : 16'h0000;
            sb_q.push_back(e);
        end
        exp_wr.delete();
        for (int i = 0; i < TOT; i++) exp_wr.push_back(ref_w[i]);
        rd_mon = 0;
        @(posedge ti_clk); #1 start = 1'b1;
        @(posedge ti_clk); #1 start = 1'b0;
        @(negedge ti_clk);
        check("start_latency", {busy, wf_wr_en}, 2'b11);
        if (mode == 1) begin
            repeat (100) @(posedge ti_clk);
            #1 start = 1'b1;
            @(posedge ti_clk); #1 start = 1'b0;
        end
        if (mode == 3) begin
            repeat (200) @(negedge ti_clk);
            force_full = 1'b1;
            hold = 0;
            repeat (50) begin
                @(negedge ti_clk);
                if (wf_wr_en) hold++;
            end
            force_full = 1'b0;
            check("full_hold_wr", hold, 0);
        end
        if (mode == 6) begin
            n = 0;
            while (!sdram_rden && n < 20000) begin @(negedge ti_clk); n++; end
            if (!sdram_rden) begin
                checks++; failures++;
                $display("FAIL reach_read actual=no_read required=read_phase");
            end
            repeat (50) @(negedge ti_clk);
            @(posedge ti_clk); #1 reset = 1'b1;
            @(posedge ti_clk);
            @(negedge ti_clk);
            check_reset("midrun_reset");
            @(posedge ti_clk); #1 reset = 1'b0;
            return;
        end
        n = 0;
        while (!done && n < 20000) begin @(negedge ti_clk); n++; end
        if (!done) begin
            checks++; failures++;
            $display("FAIL run_done actual=not_done required=done mode=%0d", mode);
        end
        repeat (3) @(negedge ti_clk);
    endtask

    initial begin
        logic [15:0] r;
        r = SEED_V;
        for (int i = 0; i < TOT; i++) begin
            ref_w[i] = r;
            r = (r >> 1) ^ (r[0] ? TAP_MASK : 16'h0000);
        end

        repeat (3) @(posedge ti_clk);
        @(negedge ti_clk);
        check_reset("reset");
        @(posedge ti_clk); #1 reset = 1'b0;

        run(1, 1, 1, 0, 0, -1);               // clean loopback, start pulse mid-run ignored
        flip_idx = 700;
        run(0, 1, 0, 0, 1, 700);              // single corrupted word
        flip_idx = -1;
        run(3, 1, 1, 0, 0, -1);               // forced full mid-write
        tog_empty = 1'b1;
        run(0, 1, 1, 0, 0, -1);               // rf_empty toggling
        tog_empty = 1'b0;
        no_drain = 1'b1;
        run(0, 1, 0, 1, 0, -1);               // PipeIn never drains -> watchdog
        no_drain = 1'b0;

        @(posedge ti_clk); #1 reset = 1'b1;
        @(posedge ti_clk); #1 reset = 1'b0;
        run(6, 0, 0, 0, 0, -1);               // reset during READ
        run(0, 1, 1, 0, 0, -1);               // clean run after the abort

        check("scoreboard_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
